// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between two cache requesters, the memory-port arbiter and main memory.
// The arbiter uses the slave view; the requester/memory side uses the master view.
interface mem_port_arbiter_if;
   logic        req0_valid;
   logic [31:0] req0_addr;
   logic [31:0] req0_wdata;
   logic [3:0]  req0_wstrb;
   logic        req0_ready;
   logic [31:0] req0_rdata;

   logic        req1_valid;
   logic [31:0] req1_addr;
   logic [31:0] req1_wdata;
   logic [3:0]  req1_wstrb;
   logic        req1_ready;
   logic [31:0] req1_rdata;

   logic        mem_valid_MP;
   logic [31:0] mem_addr_MP;
   logic [31:0] mem_wdata_MP;
   logic [3:0]  mem_wstrb_MP;
   logic        mem_ready_MP;
   logic [31:0] mem_rdata_MP;

   logic        grant;

   modport slave (
      input  req0_valid, req0_addr, req0_wdata, req0_wstrb,
      output req0_ready, req0_rdata,
      input  req1_valid, req1_addr, req1_wdata, req1_wstrb,
      output req1_ready, req1_rdata,
      output mem_valid_MP, mem_addr_MP, mem_wdata_MP, mem_wstrb_MP,
      input  mem_ready_MP, mem_rdata_MP,
      output grant
   );

   modport master (
      output req0_valid, req0_addr, req0_wdata, req0_wstrb,
      input  req0_ready, req0_rdata,
      output req1_valid, req1_addr, req1_wdata, req1_wstrb,
      input  req1_ready, req1_rdata,
      input  mem_valid_MP, mem_addr_MP, mem_wdata_MP, mem_wstrb_MP,
      output mem_ready_MP, mem_rdata_MP,
      input  grant
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared main-memory port: one word transaction at a time, round-robin or fixed priority.
// Define ARB_STATS_EN to add saturating grant/conflict statistics outputs.
module mem_port_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int CNT_W      = 21
) (
   input  logic             clk,
   input  logic             resetn,
`ifdef ARB_STATS_EN
   output logic [CNT_W-1:0] grants0,
   output logic [CNT_W-1:0] grants1,
   output logic [CNT_W-1:0] conflicts,
`endif
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   typedef logic [CNT_W-1:0] cnt_t;

   state_t state_reg;
   logic   last_grant_reg;
   logic   any_req;
   logic   both_req;
   logic   winner;

   assign any_req  = bus.req0_valid | bus.req1_valid;
   assign both_req = bus.req0_valid & bus.req1_valid;

   // On a conflict round-robin favours the port that was not served last
   always_comb begin
      winner = bus.req0_valid ? 1'b0 : 1'b1;
      if (both_req) begin
         winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_reg;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg        <= IDLE;
         last_grant_reg   <= 1'b1;
         bus.mem_valid_MP <= 1'b0;
         bus.mem_addr_MP  <= '0;
         bus.mem_wdata_MP <= '0;
         bus.mem_wstrb_MP <= '0;
         bus.grant        <= 1'b0;
         bus.req0_ready   <= 1'b0;
         bus.req0_rdata   <= '0;
         bus.req1_ready   <= 1'b0;
         bus.req1_rdata   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  bus.mem_valid_MP <= 1'b1;
                  bus.mem_addr_MP  <= winner ? bus.req1_addr  : bus.req0_addr;
                  bus.mem_wdata_MP <= winner ? bus.req1_wdata : bus.req0_wdata;
                  bus.mem_wstrb_MP <= winner ? bus.req1_wstrb : bus.req0_wstrb;
                  bus.grant        <= winner;
                  state_reg        <= BUSY;
               end
            end
            BUSY: begin
               // Completion is delivered even if the requester has since dropped valid
               if (bus.mem_ready_MP) begin
                  bus.mem_valid_MP <= 1'b0;
                  if (bus.grant) begin
                     bus.req1_rdata <= bus.mem_rdata_MP;
                     bus.req1_ready <= 1'b1;
                  end else begin
                     bus.req0_rdata <= bus.mem_rdata_MP;
                     bus.req0_ready <= 1'b1;
                  end
                  last_grant_reg <= bus.grant;
                  state_reg      <= DONE;
               end
            end
            DONE: begin
               bus.req0_ready <= 1'b0;
               bus.req1_ready <= 1'b0;
               state_reg      <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef ARB_STATS_EN
   logic [2:0] stat_inc;

   assign stat_inc[0] = (state_reg == IDLE) && any_req && !winner;
   assign stat_inc[1] = (state_reg == IDLE) && any_req && winner;
   assign stat_inc[2] = (state_reg == IDLE) && both_req;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_stat
         cnt_t cnt_reg;
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               cnt_reg <= '0;
            end else if (stat_inc[gi] && (cnt_reg != '1)) begin
               cnt_reg <= cnt_reg + cnt_t'(1);
            end
         end
      end
   endgenerate

   assign grants0   = g_stat[0].cnt_reg;
   assign grants1   = g_stat[1].cnt_reg;
   assign conflicts = g_stat[2].cnt_reg;
`endif
endmodule
